// File: rtl/rv32imf_apu_arbiter.sv
// Shares one FP APU among NUM_CH cores. Round-robin arbitration with a lock
// that pins the winner until the FP unit grants it. An in-order tag FIFO routes
// each result back to its issuer. Also drives the APU clock-gate enable, which
// stays high for CLK_HOLD cycles after the last activity.
module rv32imf_apu_arbiter #(
  parameter int NUM_CH          = 2,
  parameter int MAX_OUTSTANDING = 4,
  parameter int CLK_HOLD        = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [NUM_CH-1:0]            ch_req_i,
  output logic [NUM_CH-1:0]            ch_gnt_o,
  input  logic [NUM_CH-1:0][2:0][31:0] ch_operands_i,
  input  logic [NUM_CH-1:0][5:0]       ch_op_i,
  input  logic [NUM_CH-1:0][14:0]      ch_flags_i,
  output logic [NUM_CH-1:0]            ch_rvalid_o,
  output logic [31:0]                  ch_result_o,
  output logic [4:0]                   ch_rflags_o,
  output logic                         apu_req_o,
  input  logic                         apu_gnt_i,
  output logic [2:0][31:0]             apu_operands_o,
  output logic [5:0]                   apu_op_o,
  output logic [14:0]                  apu_flags_o,
  input  logic                         apu_rvalid_i,
  input  logic [31:0]                  apu_rdata_i,
  input  logic [4:0]                   apu_rflags_i,
  output logic                         apu_clk_en_o,
  output logic                         busy_o,
  output logic                         err_o
);

  localparam int IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int HW = (CLK_HOLD > 0) ? $clog2(CLK_HOLD + 1) : 1;

  logic [IW-1:0]                      rr_ptr_q, rr_ptr_d;
  logic                               lock_vld_q, lock_vld_d;
  logic [IW-1:0]                      lock_idx_q, lock_idx_d;
  logic [MAX_OUTSTANDING-1:0][IW-1:0] fifo_q, fifo_d;
  logic [PW-1:0]                      wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]                      rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]                      cnt_q, cnt_d;
  logic [HW-1:0]                      hold_cnt_q, hold_cnt_d;
  logic                               err_q, err_d;

  logic [IW-1:0] rr_win, cand, winner, head;
  logic          rr_found, any_req, lock_drop, fifo_full, fifo_empty;
  logic          hs, pop, activity;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + PW'(1);
  endfunction

  // Round-robin scan starting at rr_ptr
  always_comb begin
    rr_win   = rr_ptr_q;
    rr_found = 1'b0;
    cand     = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      cand = IW'((int'(rr_ptr_q) + i) % NUM_CH);
      if (!rr_found && ch_req_i[cand]) begin
        rr_win   = cand;
        rr_found = 1'b1;
      end
    end
  end

  assign any_req    = |ch_req_i;
  assign winner     = lock_vld_q ? lock_idx_q : rr_win;
  // A locked channel that withdraws must not be presented to the FP unit.
  assign lock_drop  = lock_vld_q & ~ch_req_i[lock_idx_q];
  assign fifo_full  = (cnt_q == CW'(MAX_OUTSTANDING));
  assign fifo_empty = (cnt_q == '0);
  assign apu_req_o  = any_req & ~fifo_full & ~lock_drop;
  assign hs         = apu_req_o & apu_gnt_i;
  assign pop        = apu_rvalid_i & ~fifo_empty;
  assign head       = fifo_q[rd_ptr_q];
  assign activity   = any_req | ~fifo_empty | apu_rvalid_i;

  assign apu_operands_o = any_req ? ch_operands_i[winner] : '0;
  assign apu_op_o       = any_req ? ch_op_i[winner]       : '0;
  assign apu_flags_o    = any_req ? ch_flags_i[winner]    : '0;
  assign ch_result_o    = apu_rdata_i;
  assign ch_rflags_o    = apu_rflags_i;
  assign apu_clk_en_o   = activity | (hold_cnt_q != '0);
  assign busy_o         = ~fifo_empty | any_req;
  assign err_o          = err_q;

  // Per-channel grant and result-valid decode
  always_comb begin
    ch_gnt_o    = '0;
    ch_rvalid_o = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      ch_gnt_o[i]    = hs  && (winner == IW'(i));
      ch_rvalid_o[i] = pop && (head == IW'(i));
    end
  end

  // Next state for arbitration, tag FIFO, clock hold and error flag
  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    lock_vld_d = lock_vld_q;
    lock_idx_d = lock_idx_q;
    fifo_d     = fifo_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    cnt_d      = cnt_q;

    if (hs) begin
      rr_ptr_d   = (winner == IW'(NUM_CH - 1)) ? '0 : winner + IW'(1);
      lock_vld_d = 1'b0;
    end else if (lock_drop) begin
      lock_vld_d = 1'b0;
    end else if (apu_req_o && !lock_vld_q) begin
      lock_vld_d = 1'b1;
      lock_idx_d = winner;
    end

    if (hs) begin
      fifo_d[wr_ptr_q] = winner;
      wr_ptr_d         = ptr_inc(wr_ptr_q);
    end
    if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({hs, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase

    if (activity)                hold_cnt_d = HW'(CLK_HOLD);
    else if (hold_cnt_q != '0)   hold_cnt_d = hold_cnt_q - HW'(1);
    else                         hold_cnt_d = hold_cnt_q;

    err_d = err_q | (apu_rvalid_i & fifo_empty) | lock_drop;
  end

  // State registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_ptr_q   <= '0;
      lock_vld_q <= 1'b0;
      lock_idx_q <= '0;
      fifo_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      hold_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      lock_vld_q <= lock_vld_d;
      lock_idx_q <= lock_idx_d;
      fifo_q     <= fifo_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      hold_cnt_q <= hold_cnt_d;
      err_q      <= err_d;
    end
  end

endmodule

// File: tb/tb_rv32imf_apu_arbiter.sv
// Directed bench for rv32imf_apu_arbiter: grants are checked against hand-derived
// expectations and pushed to a scoreboard; result routing is checked on pop.
module tb_rv32imf_apu_arbiter;
  localparam int NUM_CH = 2;
  localparam int MAX_OUTSTANDING = 4;
  localparam int CLK_HOLD = 2;

  localparam logic [95:0] OPS0 = {32'h3333_0000, 32'h2222_0000, 32'h1111_0000};
  localparam logic [95:0] OPS1 = {32'h3333_1111, 32'h2222_1111, 32'h1111_1111};
  localparam logic [5:0]  OP0  = 6'h05;
  localparam logic [5:0]  OP1  = 6'h0A;

  logic                         clk_i = 1'b0;
  logic                         rst_i;
  logic [NUM_CH-1:0]            ch_req_i;
  logic [NUM_CH-1:0]            ch_gnt_o;
  logic [NUM_CH-1:0][2:0][31:0] ch_operands_i;
  logic [NUM_CH-1:0][5:0]       ch_op_i;
  logic [NUM_CH-1:0][14:0]      ch_flags_i;
  logic [NUM_CH-1:0]            ch_rvalid_o;
  logic [31:0]                  ch_result_o;
  logic [4:0]                   ch_rflags_o;
  logic                         apu_req_o;
  logic                         apu_gnt_i;
  logic [2:0][31:0]             apu_operands_o;
  logic [5:0]                   apu_op_o;
  logic [14:0]                  apu_flags_o;
  logic                         apu_rvalid_i;
  logic [31:0]                  apu_rdata_i;
  logic [4:0]                   apu_rflags_i;
  logic                         apu_clk_en_o;
  logic                         busy_o;
  logic                         err_o;

  rv32imf_apu_arbiter #(
    .NUM_CH(NUM_CH), .MAX_OUTSTANDING(MAX_OUTSTANDING), .CLK_HOLD(CLK_HOLD)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .ch_req_i(ch_req_i), .ch_gnt_o(ch_gnt_o),
    .ch_operands_i(ch_operands_i), .ch_op_i(ch_op_i), .ch_flags_i(ch_flags_i),
    .ch_rvalid_o(ch_rvalid_o), .ch_result_o(ch_result_o), .ch_rflags_o(ch_rflags_o),
    .apu_req_o(apu_req_o), .apu_gnt_i(apu_gnt_i),
    .apu_operands_o(apu_operands_o), .apu_op_o(apu_op_o), .apu_flags_o(apu_flags_o),
    .apu_rvalid_i(apu_rvalid_i), .apu_rdata_i(apu_rdata_i), .apu_rflags_i(apu_rflags_i),
    .apu_clk_en_o(apu_clk_en_o), .busy_o(busy_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;
  logic [NUM_CH-1:0] sb[$];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic gnt_check(input string tag, input logic [NUM_CH-1:0] exp);
    chk(tag, ch_gnt_o, exp);
    if (exp != '0) sb.push_back(exp);
  endtask

  task automatic pop_check(input string tag);
    logic [NUM_CH-1:0] e;
    e = '0;
    if (sb.size() > 0) e = sb.pop_front();
    chk(tag, ch_rvalid_o, e);
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    ch_req_i     = '0;
    apu_gnt_i    = 1'b0;
    apu_rvalid_i = 1'b0;
    apu_rdata_i  = '0;
    apu_rflags_i = '0;
  endtask

  task automatic do_reset();
    tick();
    rst_i = 1'b1;
    idle_inputs();
    sb.delete();
    tick();
    rst_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_i = 1'b1;
    idle_inputs();
    ch_operands_i[0] = OPS0;
    ch_operands_i[1] = OPS1;
    ch_op_i[0] = OP0;
    ch_op_i[1] = OP1;
    ch_flags_i[0] = 15'h00AA;
    ch_flags_i[1] = 15'h0155;
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_gnt", ch_gnt_o, 0);
    chk("rst_rvalid", ch_rvalid_o, 0);
    chk("rst_apu_req", apu_req_o, 0);
    chk("rst_ops", apu_operands_o, 0);
    chk("rst_clk_en", apu_clk_en_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_err", err_o, 0);
    rst_i = 1'b0;

    // Single channel, response three cycles after grant, then clock hold
    tick(); ch_req_i = 2'b01; apu_gnt_i = 1'b1; #1;
    chk("single_req", apu_req_o, 1);
    gnt_check("single_gnt", 2'b01);
    chk("single_ops", apu_operands_o, OPS0);
    chk("single_op", apu_op_o, OP0);
    tick(); idle_inputs(); #1;
    chk("single_busy", busy_o, 1);
    tick();
    tick(); apu_rvalid_i = 1'b1; apu_rdata_i = 32'h3F80_0000; apu_rflags_i = 5'h01; #1;
    pop_check("single_rvalid");
    chk("single_result", ch_result_o, 32'h3F80_0000);
    chk("single_rflags", ch_rflags_o, 5'h01);
    tick(); idle_inputs(); #1;
    chk("single_empty", busy_o, 0);
    chk("hold_t1", apu_clk_en_o, 1);
    tick(); #1;
    chk("hold_t2", apu_clk_en_o, 1);
    tick(); #1;
    chk("hold_t3", apu_clk_en_o, 0);
    chk("single_err", err_o, 0);

    // Fairness until FIFO full, then backpressure and simultaneous push/pop
    do_reset();
    for (int k = 0; k < 4; k++) begin
      logic [NUM_CH-1:0] eg;
      eg = (k % 2 == 0) ? 2'b01 : 2'b10;
      tick(); ch_req_i = 2'b11; apu_gnt_i = 1'b1; #1;
      gnt_check($sformatf("fair_gnt%0d", k), eg);
      chk($sformatf("fair_ops%0d", k), apu_operands_o, (k % 2 == 0) ? OPS0 : OPS1);
    end
    tick(); #1;
    chk("full_req", apu_req_o, 0);
    chk("full_gnt", ch_gnt_o, 0);
    chk("full_busy", busy_o, 1);
    tick(); apu_rvalid_i = 1'b1; apu_rdata_i = 32'hD1; #1;
    chk("full_pop_req", apu_req_o, 0);
    chk("full_pop_gnt", ch_gnt_o, 0);
    pop_check("full_pop_rvalid");
    tick(); apu_rvalid_i = 1'b0; #1;
    chk("refill_req", apu_req_o, 1);
    gnt_check("refill_gnt", 2'b01);
    tick(); apu_rvalid_i = 1'b1; apu_rdata_i = 32'hD2; #1;
    chk("full2_req", apu_req_o, 0);
    pop_check("full2_rvalid");
    tick(); apu_rdata_i = 32'hD3; #1;
    gnt_check("pushpop_gnt", 2'b10);
    pop_check("pushpop_rvalid");
    chk("pushpop_result", ch_result_o, 32'hD3);
    tick(); ch_req_i = '0; apu_gnt_i = 1'b0; #1;
    pop_check("drain0");
    for (int k = 1; k < 3; k++) begin
      tick(); apu_rdata_i = 32'hE0 + k; #1;
      pop_check($sformatf("drain%0d", k));
    end
    tick(); idle_inputs(); #1;
    chk("fair_busy_end", busy_o, 0);
    chk("fair_err", err_o, 0);

    // Lock: ch0 stalls without grant while ch1 joins with rr_ptr pointing at ch1
    do_reset();
    tick(); ch_req_i = 2'b01; apu_gnt_i = 1'b1; #1;
    gnt_check("lock_pre_gnt", 2'b01);
    tick(); apu_gnt_i = 1'b0; #1;
    chk("lock_req", apu_req_o, 1);
    chk("lock_gnt0", ch_gnt_o, 0);
    tick(); ch_req_i = 2'b11; #1;
    chk("lock_ops1", apu_operands_o, OPS0);
    chk("lock_op1", apu_op_o, OP0);
    tick(); #1;
    chk("lock_ops2", apu_operands_o, OPS0);
    tick(); apu_gnt_i = 1'b1; #1;
    gnt_check("lock_gnt_ch0", 2'b01);
    tick(); ch_req_i = 2'b10; #1;
    gnt_check("lock_gnt_ch1", 2'b10);
    chk("lock_ops_ch1", apu_operands_o, OPS1);
    tick(); idle_inputs(); apu_rvalid_i = 1'b1; #1;
    pop_check("lock_rv0");
    for (int k = 1; k < 3; k++) begin
      tick(); #1;
      pop_check($sformatf("lock_rv%0d", k));
    end
    chk("lock_err", err_o, 0);

    // Spurious rvalid with empty FIFO: sticky error
    tick(); #1;
    chk("spur_rvalid", ch_rvalid_o, 0);
    tick(); apu_rvalid_i = 1'b0; #1;
    chk("spur_err", err_o, 1);
    tick(); #1;
    chk("spur_err_sticky", err_o, 1);

    // Locked channel dropping its request
    do_reset();
    chk("drop_err_clr", err_o, 0);
    tick(); ch_req_i = 2'b01; #1;
    tick(); ch_req_i = 2'b00; #1;
    tick(); #1;
    chk("drop_err", err_o, 1);
    tick(); ch_req_i = 2'b10; apu_gnt_i = 1'b1; #1;
    gnt_check("drop_resume_gnt", 2'b10);
    tick(); idle_inputs(); apu_rvalid_i = 1'b1; #1;
    pop_check("drop_rv");

    // Reset in the middle of a burst; late result is spurious
    do_reset();
    tick(); ch_req_i = 2'b11; apu_gnt_i = 1'b1; #1;
    gnt_check("mid_gnt0", 2'b01);
    tick(); #1;
    gnt_check("mid_gnt1", 2'b10);
    #1; rst_i = 1'b1; idle_inputs(); sb.delete(); #1;
    chk("mid_busy", busy_o, 0);
    chk("mid_err", err_o, 0);
    chk("mid_clk_en", apu_clk_en_o, 0);
    tick(); rst_i = 1'b0;
    tick(); apu_rvalid_i = 1'b1; apu_rdata_i = 32'hBAD; #1;
    chk("mid_late_rvalid", ch_rvalid_o, 0);
    tick(); apu_rvalid_i = 1'b0; #1;
    chk("mid_late_err", err_o, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
